alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: IDLE -> EXEC -> RESP per operation.
// Build option ALU_ARBITER_FIXED_PRIO_EN: requester 0 always wins ties (default is round-robin).
//
// state | meaning
// IDLE  | arbitrate between valid requesters, latch operands on handshake
// EXEC  | latched operands on the ALU, capture alu_out into result register
// RESP  | present result to granted requester until it takes it
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_in1,
  input  logic [31:0] req0_in2,
  input  logic [3:0]  req0_op,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_in1,
  input  logic [31:0] req1_in2,
  input  logic [3:0]  req1_op,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_data,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_out
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] in1_q, in1_d;
  logic [31:0] in2_q, in2_d;
  logic [3:0]  op_q, op_d;
  logic        gnt_q, gnt_d;
  logic [31:0] result_q, result_d;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
  logic        last_grant_q, last_grant_d;
`endif

  logic any_valid;
  logic sel;
  logic grant_now;

  assign any_valid = req0_valid | req1_valid;

  always_comb begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
    sel = ~req0_valid;
`else
    // On a tie, favour whoever did not win last time
    if (req0_valid && req1_valid) sel = ~last_grant_q;
    else                          sel = ~req0_valid;
`endif
  end

  assign grant_now = (state_q == IDLE) && any_valid;

  always_comb begin
    state_d  = state_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    op_d     = op_q;
    gnt_d    = gnt_q;
    result_d = result_q;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          in1_d   = sel ? req1_in1 : req0_in1;
          in2_d   = sel ? req1_in2 : req0_in2;
          op_d    = sel ? req1_op  : req0_op;
          gnt_d   = sel;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
          last_grant_d = sel;
`endif
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_out;
        state_d  = RESP;
      end
      RESP: begin
        if (gnt_q ? resp1_ready : resp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      in1_q    <= '0;
      in2_q    <= '0;
      op_q     <= '0;
      gnt_q    <= 1'b0;
      result_q <= '0;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      op_q     <= op_d;
      gnt_q    <= gnt_d;
      result_q <= result_d;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Outputs are forced quiet while rst is high, even before the reset edge lands
  assign req0_ready  = !rst && grant_now && !sel;
  assign req1_ready  = !rst && grant_now &&  sel;
  assign resp0_valid = !rst && (state_q == RESP) && !gnt_q;
  assign resp1_valid = !rst && (state_q == RESP) &&  gnt_q;
  assign resp0_data  = result_q;
  assign resp1_data  = result_q;
  assign alu_in1     = rst ? 32'd0 : in1_q;
  assign alu_in2     = rst ? 32'd0 : in2_q;
  assign alu_op      = rst ? 4'd0  : op_q;

endmodule
